// File: rtl/path_meter_pkg.sv
// Shared types and sizing helpers for the path delay meter.
// Imported by the meter top and its synchronizer.
package path_meter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    LAUNCH,
    WAIT,
    REPORT
  } state_e;

  localparam int CNT_W_DEF       = 16;
  localparam int TRIALS_LOG2_DEF = 4;
  localparam int TRIALS          = 2 ** TRIALS_LOG2_DEF;
  localparam int SUM_W           = CNT_W_DEF + TRIALS_LOG2_DEF;

  function automatic int sum_width(input int cnt_w, input int tl2);
    return cnt_w + tl2;
  endfunction

endpackage

// File: rtl/path_sync.sv
// Multi-flop bit synchronizer for the asynchronous chain output.
// All stages clear to 0 on synchronous reset.
import path_meter_pkg::*;

module path_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE", keep = "true" *)
  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/path_delay_meter.sv
// Launch/capture timer: toggles a delay chain input and sums the
// cycles until the edge returns, over 2**TRIALS_LOG2 trials.
import path_meter_pkg::*;

module path_delay_meter #(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TRIALS_LOG2 = TRIALS_LOG2_DEF,
  parameter int TIMEOUT     = 4095,
  parameter int SYNC_STAGES = 2,
  parameter bit INVERT      = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         busy,
  output logic                         path_launch,
  input  logic                         path_sample,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic [CNT_W+TRIALS_LOG2-1:0] result_sum,
  output logic                         timeout_err
);

  localparam int SW = sum_width(CNT_W, TRIALS_LOG2);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [TRIALS_LOG2-1:0] trial_q;
  logic [SW-1:0]    sum_q;
  logic             launch_q;
  logic             valid_q;
  logic             terr_q;
  logic             s;
  logic             exp_lvl;
  logic             hit_tmo;
  logic             last;

  path_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (path_sample),
    .q_o  (s)
  );

  assign exp_lvl = launch_q ^ INVERT;
  assign cnt_d   = cnt_q + 1'b1;
  assign hit_tmo = (cnt_d == CNT_W'(TIMEOUT));
  assign last    = &trial_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      trial_q  <= '0;
      sum_q    <= '0;
      launch_q <= 1'b0;
      valid_q  <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ARM;
            sum_q   <= '0;
            trial_q <= '0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
          end
        end
        ARM: begin
          if (s == exp_lvl) begin
            state_q <= LAUNCH;
          end else if (hit_tmo) begin
            state_q <= REPORT;
            terr_q  <= 1'b1;
            sum_q   <= '1;
            valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        LAUNCH: begin
          launch_q <= ~launch_q;
          cnt_q    <= '0;
          state_q  <= WAIT;
        end
        WAIT: begin
          if (s != exp_lvl) begin
            if (hit_tmo) begin
              state_q <= REPORT;
              terr_q  <= 1'b1;
              sum_q   <= '1;
              valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_d;
            end
          end else begin
            sum_q   <= sum_q + SW'(cnt_q);
            trial_q <= trial_q + 1'b1;
            cnt_q   <= '0;
            if (last) begin
              state_q <= REPORT;
              valid_q <= 1'b1;
            end else begin
              state_q <= ARM;
            end
          end
        end
        REPORT: begin
          if (result_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = (state_q != IDLE);
  assign path_launch  = launch_q;
  assign result_valid = valid_q;
  assign result_sum   = sum_q;
  assign timeout_err  = terr_q;

endmodule

// File: tb/tb_path_delay_meter.sv
// Directed bench for path_delay_meter: table of chain models plus
// hand sequences for back-pressure, mid-run reset and ignored starts.
module tb_path_delay_meter;

  localparam int SW  = 20;
  localparam int LIM = 12000;

  logic clk = 1'b0;
  logic rst_n;
  logic rdy;
  logic st0, st1;
  logic busy0, busy1, ln0, ln1, smp0, smp1;
  logic val0, val1, te0, te1;
  logic [SW-1:0] sum0, sum1;
  logic [1:0] mode;
  logic [4:0] dly = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) dly <= {dly[3:0], ln0};

  assign smp0 = (mode == 2'd0) ? ln0 :
                (mode == 2'd1) ? dly[4] :
                (mode == 2'd2) ? 1'b0 : ~ln0;
  assign smp1 = ~ln1;

  path_delay_meter #(.INVERT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(st0), .busy(busy0),
    .path_launch(ln0), .path_sample(smp0),
    .result_valid(val0), .result_ready(rdy),
    .result_sum(sum0), .timeout_err(te0)
  );

  path_delay_meter #(.INVERT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .busy(busy1),
    .path_launch(ln1), .path_sample(smp1),
    .result_valid(val1), .result_ready(rdy),
    .result_sum(sum1), .timeout_err(te1)
  );

  typedef struct {
    logic [1:0]    md;
    logic [SW-1:0] e_sum;
    logic          e_te;
    logic          e_ln;
    string         nm;
  } vec_t;

  vec_t tv[4];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start0();
    st0 = 1'b1;
    tick();
    st0 = 1'b0;
  endtask

  task automatic wait_val0(input string nm);
    int n;
    n = 0;
    while (!val0 && n < LIM) begin
      tick();
      n++;
    end
    chk({nm, "_valid_seen"}, 32'(val0), 32'd1);
  endtask

  task automatic accept0(input string nm);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    chk({nm, "_valid_drop"}, 32'(val0), 32'd0);
    chk({nm, "_idle"}, 32'(busy0), 32'd0);
  endtask

  initial begin
    int n;
    int tog;
    logic prev;

    tv[0] = '{2'd0, 20'd32,    1'b0, 1'b0, "loop"};
    tv[1] = '{2'd1, 20'd112,   1'b0, 1'b0, "dly5"};
    tv[2] = '{2'd3, 20'hFFFFF, 1'b1, 1'b0, "inv_noinv"};
    tv[3] = '{2'd2, 20'hFFFFF, 1'b1, 1'b1, "stuck0"};

    rst_n = 1'b0;
    rdy   = 1'b0;
    st0   = 1'b0;
    st1   = 1'b0;
    mode  = 2'd0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_valid", 32'(val0), 32'd0);
    chk("rst_launch", 32'(ln0), 32'd0);
    chk("rst_sum", 32'(sum0), 32'd0);
    chk("rst_terr", 32'(te0), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      mode = tv[i].md;
      repeat (10) tick();
      pulse_start0();
      chk({tv[i].nm, "_busy"}, 32'(busy0), 32'd1);
      wait_val0(tv[i].nm);
      chk({tv[i].nm, "_sum"}, 32'(sum0), 32'(tv[i].e_sum));
      chk({tv[i].nm, "_terr"}, 32'(te0), 32'(tv[i].e_te));
      chk({tv[i].nm, "_launch"}, 32'(ln0), 32'(tv[i].e_ln));
      accept0(tv[i].nm);
    end

    // back-pressure: result held while ready stays low
    do_reset();
    mode = 2'd1;
    repeat (10) tick();
    pulse_start0();
    wait_val0("hold");
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("hold_valid", 32'(val0), 32'd1);
      chk("hold_sum", 32'(sum0), 32'd112);
      chk("hold_terr", 32'(te0), 32'd0);
      chk("hold_busy", 32'(busy0), 32'd1);
    end
    accept0("hold");

    // inverting chain on the INVERT=1 instance
    repeat (5) tick();
    st1 = 1'b1;
    tick();
    st1 = 1'b0;
    n = 0;
    while (!val1 && n < LIM) begin
      tick();
      n++;
    end
    chk("inv1_valid", 32'(val1), 32'd1);
    chk("inv1_sum", 32'(sum1), 32'd32);
    chk("inv1_terr", 32'(te1), 32'd0);
    chk("inv1_launch", 32'(ln1), 32'd0);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    chk("inv1_idle", 32'(busy1), 32'd0);

    // reset during WAIT of trial 7
    do_reset();
    mode = 2'd0;
    repeat (5) tick();
    pulse_start0();
    tog  = 0;
    prev = ln0;
    n    = 0;
    while (tog < 7 && n < 500) begin
      tick();
      if (ln0 != prev) tog++;
      prev = ln0;
      n++;
    end
    chk("mid_trial7", 32'(tog), 32'd7);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_busy", 32'(busy0), 32'd0);
    chk("mid_launch", 32'(ln0), 32'd0);
    chk("mid_valid", 32'(val0), 32'd0);
    repeat (5) tick();
    pulse_start0();
    wait_val0("after_rst");
    chk("after_rst_sum", 32'(sum0), 32'd32);
    accept0("after_rst");

    // starts while busy and during REPORT are ignored
    repeat (5) tick();
    pulse_start0();
    for (int k = 0; k < 6; k++) begin
      tick();
      pulse_start0();
    end
    wait_val0("ign");
    chk("ign_sum", 32'(sum0), 32'd32);
    pulse_start0();
    chk("ign_rep_busy", 32'(busy0), 32'd1);
    chk("ign_rep_valid", 32'(val0), 32'd1);
    rdy = 1'b1;
    st0 = 1'b1;
    tick();
    rdy = 1'b0;
    st0 = 1'b0;
    chk("ign_hs_busy", 32'(busy0), 32'd0);
    chk("ign_hs_valid", 32'(val0), 32'd0);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (busy0 || val0) n++;
    end
    chk("ign_no_extra", 32'(n), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
